rope_array_ctrl: RTL and testbench

Parametrised controller for a bank of NUM_ROPES horizontally moving ropes.
- Keeps a fixed-point X position, a direction and a grab/hold state machine for every rope.
- Moves ropes once per frame, bounces them at playfield limits, and freezes a rope while the monkey holds it.
- Generates registered per-rope and merged drawing requests/RGB for the VGA object mux. It replaces the fixed three-left/three-right rope display arrangement.

---
 rtl/rope_array_if.sv | 28 ++
 rtl/rope_array_ctrl.sv | 158 +++++++++++++++
 tb/tb_rope_array_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rope_array_if.sv
// Bundle of frame, pixel, per-rope control and drawing signals shared by the
// rope bank controller and whatever drives it (frame timing plus game logic).
interface rope_array_if #(
  parameter int NUM_ROPES = 6
);
  logic                         startOfFrame;
  logic [10:0]                  pixelX;
  logic [10:0]                  pixelY;
  logic [NUM_ROPES-1:0]         dirToggle;
  logic [NUM_ROPES-1:0]         monkeyCollision;
  logic [NUM_ROPES-1:0][6:0]    X_SPEED;
  logic [NUM_ROPES-1:0]         ropeDR;
  logic                         anyRopeDR;
  logic [7:0]                   ropeRGB;
  logic [NUM_ROPES-1:0][10:0]   ropeX;
  logic [NUM_ROPES-1:0]         ropeHeld;
  logic [NUM_ROPES-1:0][31:0]   SIGNED_SPEEDS;

  modport master (
    output startOfFrame, pixelX, pixelY, dirToggle, monkeyCollision, X_SPEED,
    input  ropeDR, anyRopeDR, ropeRGB, ropeX, ropeHeld, SIGNED_SPEEDS
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, dirToggle, monkeyCollision, X_SPEED,
    output ropeDR, anyRopeDR, ropeRGB, ropeX, ropeHeld, SIGNED_SPEEDS
  );
endinterface

// File: rtl/rope_array_ctrl.sv
// Bank of horizontally moving ropes: fixed-point position, direction and a
// grab/hold FSM per rope, plus registered drawing requests for the VGA mux.
// Build macro ROPE_WRAP_EN: ropes wrap around at the playfield limits
// instead of bouncing.
module rope_array_ctrl #(
  parameter int         NUM_ROPES   = 6,
  parameter int         LEFT_ROPES  = 3,
  parameter int         LEFT_X0     = 100,
  parameter int         RIGHT_X0    = 400,
  parameter int         Y0          = 100,
  parameter int         ROPE_W      = 4,
  parameter int         ROPE_H      = 300,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         FRAC_BITS   = 2,
  parameter int         HOLD_FRAMES = 30,
  parameter logic [7:0] ROPE_COLOR  = 8'hB4
) (
  input logic         clk,
  input logic         reset,
  rope_array_if.slave bus
);
  // state | meaning
  // MOVE  | rope advances by X_SPEED on every frame update
  // HELD  | rope frozen by the monkey; counter holds frames left until release

  localparam int PW   = FRAC_BITS + 12;
  localparam int RMAX = X_MAX - ROPE_W + 1;
  localparam int CW   = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic signed [PW-1:0] POS_LO  = PW'(X_MIN << FRAC_BITS);
  localparam logic signed [PW-1:0] POS_HI  = PW'(RMAX << FRAC_BITS);
  localparam logic signed [PW-1:0] INT_HI  = PW'(RMAX);
  localparam logic [CW-1:0]        HOLD_LD = CW'(HOLD_FRAMES);

  typedef enum logic {MOVE, HELD} state_t;

  state_t               st    [NUM_ROPES];
  logic signed [PW-1:0] pos   [NUM_ROPES];
  logic [CW-1:0]        cnt   [NUM_ROPES];
  logic [NUM_ROPES-1:0] dir_l;
  logic [NUM_ROPES-1:0] pend;

  logic signed [PW-1:0] nx    [NUM_ROPES];
  logic [10:0]          xint  [NUM_ROPES];
  logic [NUM_ROPES-1:0] over_hi;
  logic [NUM_ROPES-1:0] under_lo;
  logic [NUM_ROPES-1:0] pend_eff;
  logic [NUM_ROPES-1:0] hit;

  function automatic logic signed [PW-1:0] init_pos(int i);
    return PW'(((i < LEFT_ROPES) ? LEFT_X0 : RIGHT_X0) << FRAC_BITS);
  endfunction

  // status outputs derived straight from the per-rope state
  always_comb begin
    for (int i = 0; i < NUM_ROPES; i++) begin
      xint[i]            = pos[i][FRAC_BITS +: 11];
      bus.ropeX[i]       = xint[i];
      bus.ropeHeld[i]    = (st[i] == HELD);
      if (st[i] == HELD)
        bus.SIGNED_SPEEDS[i] = '0;
      else if (dir_l[i])
        bus.SIGNED_SPEEDS[i] = -32'(bus.X_SPEED[i]);
      else
        bus.SIGNED_SPEEDS[i] = 32'(bus.X_SPEED[i]);
    end
  end

  // candidate move, limit tests and pixel hit for every rope
  always_comb begin
    for (int i = 0; i < NUM_ROPES; i++) begin
      nx[i]       = dir_l[i] ? pos[i] - PW'(bus.X_SPEED[i])
                             : pos[i] + PW'(bus.X_SPEED[i]);
      over_hi[i]  = (nx[i] >>> FRAC_BITS) > INT_HI;
      under_lo[i] = nx[i] < POS_LO;
      pend_eff[i] = pend[i] | bus.dirToggle[i];
      hit[i]      = (bus.pixelX >= xint[i]) &&
                    ({1'b0, bus.pixelX} <= {1'b0, xint[i]} + 12'(ROPE_W - 1)) &&
                    (bus.pixelY >= 11'(Y0)) &&
                    (bus.pixelY <= 11'(Y0 + ROPE_H - 1));
    end
  end

  // per-rope grab/hold FSM and frame-rate position update
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ROPES; i++) begin
      if (reset) begin
        st[i]    <= MOVE;
        pos[i]   <= init_pos(i);
        cnt[i]   <= '0;
        dir_l[i] <= 1'b0;
        pend[i]  <= 1'b0;
      end else begin
        case (st[i])
          MOVE: begin
            if (bus.monkeyCollision[i]) begin
              // grabbing wins over a coincident frame update; toggles are kept
              st[i]   <= HELD;
              cnt[i]  <= HOLD_LD;
              pend[i] <= pend_eff[i];
            end else if (bus.startOfFrame) begin
              pend[i] <= 1'b0;
`ifdef ROPE_WRAP_EN
              dir_l[i] <= dir_l[i] ^ pend_eff[i];
              if (over_hi[i])       pos[i] <= POS_LO;
              else if (under_lo[i]) pos[i] <= POS_HI;
              else                  pos[i] <= nx[i];
`else
              // the move uses the current direction; a toggle only takes
              // effect afterwards and loses to a wall bounce
              if (over_hi[i]) begin
                pos[i]   <= POS_HI;
                dir_l[i] <= 1'b1;
              end else if (under_lo[i]) begin
                pos[i]   <= POS_LO;
                dir_l[i] <= 1'b0;
              end else begin
                pos[i]   <= nx[i];
                dir_l[i] <= dir_l[i] ^ pend_eff[i];
              end
`endif
            end else begin
              pend[i] <= pend_eff[i];
            end
          end
          HELD: begin
            pend[i] <= pend_eff[i];
            if (bus.monkeyCollision[i]) begin
              cnt[i] <= HOLD_LD;
            end else if (bus.startOfFrame) begin
              if (cnt[i] <= CW'(1)) begin
                cnt[i] <= '0;
                st[i]  <= MOVE;
              end else begin
                cnt[i] <= cnt[i] - CW'(1);
              end
            end
          end
          default: st[i] <= MOVE;
        endcase
      end
    end
  end

  // drawing requests registered one clock behind the pixel coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ropeDR    <= '0;
      bus.anyRopeDR <= 1'b0;
      bus.ropeRGB   <= 8'h00;
    end else begin
      bus.ropeDR    <= hit;
      bus.anyRopeDR <= |hit;
      bus.ropeRGB   <= (|hit) ? ROPE_COLOR : 8'h00;
    end
  end
endmodule

// File: tb/tb_rope_array_ctrl.sv
// Bench for rope_array_ctrl: constant-table sequence, directed corner cases
// and a randomized run against a pixel/quarter-pixel arithmetic model.
module tb_rope_array_ctrl;
  localparam int N    = 6;
  localparam int HOLD = 3;
  localparam int RMAX = 636;
  localparam int XMIN = 0;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rope_array_if #(.NUM_ROPES(N)) bus();

  rope_array_ctrl #(.HOLD_FRAMES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: positions in quarter pixels, plain integer rules
  int mpos  [N];
  int mcnt  [N];
  bit mleft [N];
  bit mheld [N];
  bit mpend [N];
  bit mdr   [N];

  typedef struct {
    bit         sof;
    int         px;
    int         py;
    int         x0;
    bit         dr0;
    logic [7:0] rgb;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mpos[i]  = ((i < 3) ? 100 : 400) * 4;
      mcnt[i]  = 0;
      mleft[i] = 1'b0;
      mheld[i] = 1'b0;
      mpend[i] = 1'b0;
    end
  endtask

  task automatic model_clk(input bit s, input logic [N-1:0] t,
                           input logic [N-1:0] c, input bit r);
    int px, py, spd, np;
    bit flip;
    px = int'(bus.pixelX);
    py = int'(bus.pixelY);
    for (int i = 0; i < N; i++)
      mdr[i] = !r && px >= mpos[i] / 4 && px <= mpos[i] / 4 + 3 &&
               py >= 100 && py <= 399;
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      spd = int'(bus.X_SPEED[i]);
      if (mheld[i]) begin
        mpend[i] |= t[i];
        if (c[i]) mcnt[i] = HOLD;
        else if (s) begin
          mcnt[i]--;
          if (mcnt[i] <= 0) begin
            mcnt[i]  = 0;
            mheld[i] = 1'b0;
          end
        end
      end else if (c[i]) begin
        mheld[i] = 1'b1;
        mcnt[i]  = HOLD;
        mpend[i] |= t[i];
      end else if (s) begin
        flip     = mpend[i] | t[i];
        mpend[i] = 1'b0;
        np       = mleft[i] ? mpos[i] - spd : mpos[i] + spd;
`ifdef ROPE_WRAP_EN
        if (np >= (RMAX + 1) * 4) np = XMIN * 4;
        else if (np < XMIN * 4)   np = RMAX * 4;
        mleft[i] ^= flip;
`else
        if (np >= (RMAX + 1) * 4) begin
          np       = RMAX * 4;
          mleft[i] = 1'b1;
        end else if (np < XMIN * 4) begin
          np       = XMIN * 4;
          mleft[i] = 1'b0;
        end else begin
          mleft[i] ^= flip;
        end
`endif
        mpos[i] = np;
      end else begin
        mpend[i] |= t[i];
      end
    end
  endtask

  task automatic check_all();
    int  spd, es;
    bit  any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      spd = int'(bus.X_SPEED[i]);
      es  = mheld[i] ? 0 : (mleft[i] ? -spd : spd);
      any |= mdr[i];
      chk($sformatf("ropeX[%0d]", i), bus.ropeX[i], mpos[i] / 4);
      chk($sformatf("ropeHeld[%0d]", i), bus.ropeHeld[i], mheld[i]);
      chk($sformatf("speed[%0d]", i), $signed(bus.SIGNED_SPEEDS[i]), es);
      chk($sformatf("ropeDR[%0d]", i), bus.ropeDR[i], mdr[i]);
    end
    chk("anyRopeDR", bus.anyRopeDR, any);
    chk("ropeRGB", bus.ropeRGB, any ? 8'hB4 : 8'h00);
  endtask

  task automatic step(input bit s, input logic [N-1:0] t,
                      input logic [N-1:0] c, input bit r);
    bus.startOfFrame    = s;
    bus.dirToggle       = t;
    bus.monkeyCollision = c;
    reset               = r;
    @(posedge clk);
    model_clk(s, t, c, r);
    #1;
    check_all();
    bus.startOfFrame    = 1'b0;
    bus.dirToggle       = '0;
    bus.monkeyCollision = '0;
    reset               = 1'b0;
  endtask

  task automatic set_speeds(input int v);
    for (int i = 0; i < N; i++) bus.X_SPEED[i] = 7'(v);
  endtask

  task automatic do_reset();
    bus.pixelX = '0;
    bus.pixelY = '0;
    step(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.startOfFrame    = 1'b0;
    bus.dirToggle       = '0;
    bus.monkeyCollision = '0;
    bus.pixelX          = '0;
    bus.pixelY          = '0;
    set_speeds(0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    tbl[0] = '{1'b0, 101, 150, 100, 1'b1, 8'hB4};
    tbl[1] = '{1'b0,  99, 150, 100, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 103, 150, 102, 1'b1, 8'hB4};
    tbl[3] = '{1'b1, 105, 150, 104, 1'b1, 8'hB4};
    tbl[4] = '{1'b1, 104,  99, 106, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 106, 399, 106, 1'b1, 8'hB4};
    tbl[6] = '{1'b0, 110, 400, 106, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 109, 100, 106, 1'b1, 8'hB4};
    tbl[8] = '{1'b0, 110, 100, 106, 1'b0, 8'h00};

    // reset state
    do_reset();
    for (int i = 0; i < N; i++) begin
      chk("rst_x", bus.ropeX[i], (i < 3) ? 100 : 400);
      chk("rst_held", bus.ropeHeld[i], 0);
    end
    chk("rst_dr", bus.ropeDR, 0);
    chk("rst_any", bus.anyRopeDR, 0);
    chk("rst_rgb", bus.ropeRGB, 0);

    // table: rope 0 moving at 2 px/frame, pixel scans around it
    bus.X_SPEED[0] = 7'd8;
    for (int k = 0; k < 9; k++) begin
      bus.pixelX = 11'(tbl[k].px);
      bus.pixelY = 11'(tbl[k].py);
      step(tbl[k].sof, '0, '0, 1'b0);
      chk($sformatf("tbl%0d_x0", k), bus.ropeX[0], tbl[k].x0);
      chk($sformatf("tbl%0d_dr0", k), bus.ropeDR[0], tbl[k].dr0);
      chk($sformatf("tbl%0d_rgb", k), bus.ropeRGB, tbl[k].rgb);
      chk($sformatf("tbl%0d_spd0", k), $signed(bus.SIGNED_SPEEDS[0]), 8);
    end

    // several toggles in one frame give a single flip
    do_reset();
    set_speeds(8);
    for (int k = 0; k < 3; k++) step(1'b0, 6'b000010, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    chk("tog_x_a", bus.ropeX[1], 102);
    chk("tog_spd_a", $signed(bus.SIGNED_SPEEDS[1]), -8);
    step(1'b1, '0, '0, 1'b0);
    chk("tog_x_b", bus.ropeX[1], 100);
    for (int k = 0; k < 2; k++) step(1'b0, 6'b000010, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    chk("tog_x_c", bus.ropeX[1], 98);
    chk("tog_spd_c", $signed(bus.SIGNED_SPEEDS[1]), 8);
    step(1'b1, '0, '0, 1'b0);
    chk("tog_x_d", bus.ropeX[1], 100);

`ifndef ROPE_WRAP_EN
    // right wall clamp, coincident toggle loses to the bounce
    do_reset();
    set_speeds(0);
    bus.X_SPEED[3] = 7'd8;
    for (int k = 0; k < 117; k++) step(1'b1, '0, '0, 1'b0);
    chk("wall_pre", bus.ropeX[3], 634);
    bus.X_SPEED[3] = 7'd16;
    step(1'b1, 6'b001000, '0, 1'b0);
    chk("wall_x", bus.ropeX[3], 636);
    chk("wall_spd", $signed(bus.SIGNED_SPEEDS[3]), -16);
    step(1'b1, '0, '0, 1'b0);
    chk("wall_x2", bus.ropeX[3], 632);
    chk("wall_spd2", $signed(bus.SIGNED_SPEEDS[3]), -16);
`endif

    // one-cycle grab holds the rope for HOLD frames
    do_reset();
    set_speeds(8);
    step(1'b0, '0, 6'b000100, 1'b0);
    chk("hold_held", bus.ropeHeld[2], 1);
    chk("hold_spd", $signed(bus.SIGNED_SPEEDS[2]), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, '0, '0, 1'b0);
      chk($sformatf("hold_x%0d", k), bus.ropeX[2], 100);
    end
    chk("hold_rel", bus.ropeHeld[2], 0);
    step(1'b1, '0, '0, 1'b0);
    chk("hold_move", bus.ropeX[2], 102);

    // reset in mid-frame while held with a pending toggle
    do_reset();
    set_speeds(8);
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, '0, 6'b000001, 1'b0);
    step(1'b0, 6'b000001, '0, 1'b0);
    bus.pixelX = 11'd105;
    bus.pixelY = 11'd150;
    step(1'b1, 6'b000001, 6'b000001, 1'b1);
    chk("mrst_x0", bus.ropeX[0], 100);
    chk("mrst_x3", bus.ropeX[3], 400);
    chk("mrst_held", bus.ropeHeld[0], 0);
    chk("mrst_dr", bus.ropeDR, 0);
    chk("mrst_any", bus.anyRopeDR, 0);
    chk("mrst_rgb", bus.ropeRGB, 0);
    bus.pixelX = '0;
    bus.pixelY = '0;
    step(1'b1, '0, '0, 1'b0);
    chk("mrst_x0b", bus.ropeX[0], 102);
    chk("mrst_spd", $signed(bus.SIGNED_SPEEDS[0]), 8);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < N; i++) bus.X_SPEED[i] = 7'($urandom_range(0, 127));
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] t, c;
      int j;
      for (int i = 0; i < N; i++) begin
        t[i] = ($urandom_range(0, 15) == 0);
        c[i] = ($urandom_range(0, 63) == 0);
      end
      if ($urandom_range(0, 199) == 0)
        bus.X_SPEED[$urandom_range(0, N - 1)] = 7'($urandom_range(0, 127));
      j = int'($urandom_range(0, N - 1));
      bus.pixelX = 11'(mpos[j] / 4 + int'($urandom_range(0, 7)) - 2);
      bus.pixelY = 11'($urandom_range(95, 405));
      step($urandom_range(0, 2) == 0, t, c, $urandom_range(0, 599) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
